// File: rtl/wb_gpu_loader_if.sv
// Command handshake and Wishbone classic write bus for the GPU fill loader.
// master: the loader (takes commands, drives the Wishbone master side).
// slave : the command producer / Wishbone slave side (testbench or fabric).
interface wb_gpu_loader_if;
    localparam int unsigned AW = 27;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned LW = 8;

    // command channel
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_data;
    logic [SW-1:0] i_cmd_sel;
    logic [LW-1:0] i_cmd_len;

    // Wishbone classic master
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_ack_i;

    modport master (
        input  i_cmd_valid, i_cmd_addr, i_cmd_data, i_cmd_sel, i_cmd_len, wb_ack_i,
        output o_cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

    modport slave (
        output i_cmd_valid, i_cmd_addr, i_cmd_data, i_cmd_sel, i_cmd_len, wb_ack_i,
        input  o_cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
endinterface

// File: rtl/wb_gpu_loader.sv
// Wishbone classic write-fill loader: accepts one command (addr, data, sel,
// len) and writes the same data word to len+1 consecutive addresses, one beat
// per cycle at most, aborting a beat that is not acknowledged within TIMEOUT.
// Ports:
//   clk_100MHz, reset_n : clock, async active-low reset
//   bus                 : command handshake + Wishbone master (master modport)
//   o_busy              : state is not IDLE
//   o_done              : one-cycle pulse after the last beat is acknowledged
//   o_error             : sticky timeout flag, cleared by the next accepted command
module wb_gpu_loader #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    wb_gpu_loader_if.master   bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);
    localparam int unsigned AW = 27;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned LW = 8;
    localparam int unsigned TW = 8;

    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
    localparam logic [AW-1:0] STEP_C    = AW'(ADDR_STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_ABORT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] adr_q,   adr_d;
    logic [DW-1:0] dat_q,   dat_d;
    logic [SW-1:0] sel_q,   sel_d;
    logic [LW-1:0] rem_q,   rem_d;
    logic [TW-1:0] tmo_q,   tmo_d;
    logic          cyc_q,   cyc_d;
    logic          busy_q,  busy_d;
    logic          ready_q, ready_d;
    logic          done_q,  done_d;
    logic          error_q, error_d;

    // State register and datapath flops
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rem_q   <= '0;
            tmo_q   <= '0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        error_d = error_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_cmd_valid) begin
                    adr_d   = bus.i_cmd_addr;
                    dat_d   = bus.i_cmd_data;
                    sel_d   = bus.i_cmd_sel;
                    rem_d   = bus.i_cmd_len;
                    tmo_d   = '0;
                    error_d = 1'b0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // An ack wins over a timeout reached in the same cycle.
                if (bus.wb_ack_i) begin
                    tmo_d = '0;
                    if (rem_q != '0) begin
                        adr_d = adr_q + STEP_C;
                        rem_d = rem_q - LW'(1);
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TIMEOUT_C) begin
                        tmo_d   = '0;
                        error_d = 1'b1;
                        state_d = S_ABORT;
                    end
                end
            end
            S_ABORT: begin
                rem_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flops track the state being entered so they stay registered.
        cyc_d   = (state_d == S_BUS);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    assign bus.o_cmd_ready = ready_q;
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.wb_we_o     = cyc_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.wb_sel_o    = sel_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_error         = error_q;
endmodule

// File: tb/tb_wb_gpu_loader.sv
// Self-checking bench for wb_gpu_loader (TIMEOUT=8, ADDR_STEP=4).
module tb_wb_gpu_loader;
    localparam int unsigned TMO  = 8;
    localparam int unsigned STEP = 4;
    localparam int          NV   = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy, done, err;

    wb_gpu_loader_if bus();

    wb_gpu_loader #(.TIMEOUT(TMO), .ADDR_STEP(STEP)) dut (
        .clk_100MHz (clk),
        .reset_n    (rst_n),
        .bus        (bus),
        .o_busy     (busy),
        .o_done     (done),
        .o_error    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } beat_t;

    typedef struct {
        logic [26:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [7:0]  len;
        int          delay;
        int          beats;
        logic [26:0] last;
        int          ndone;
        int          err;
        int          ncyc;
    } vec_t;

    beat_t obs_q[$];
    beat_t exp_q[$];
    vec_t  vec[NV];

    int tests = 0;
    int fails = 0;

    // slave / monitor state
    int    ack_delay = 0;
    bit    rnd_ack   = 1'b0;
    int    wcnt      = 0;
    int    cur_delay = 0;
    int    done_cnt  = 0;
    int    cyc_cnt   = 0;
    int    proto_err = 0;
    bit    prev_pend = 1'b0;
    bit    prev_done = 1'b0;
    beat_t prev_beat;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Wishbone slave + protocol monitor; the beat is recorded when the ack is
    // decided, since outputs cannot move before the next rising edge.
    initial begin
        bus.wb_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wb_cyc_o !== bus.wb_stb_o || bus.wb_we_o !== bus.wb_cyc_o) proto_err++;
            if (done === 1'b1) begin
                done_cnt++;
                if (prev_done) proto_err++;
                if (bus.wb_cyc_o !== 1'b0) proto_err++;
            end
            prev_done = (done === 1'b1);
            if (bus.wb_stb_o === 1'b1) begin
                cyc_cnt++;
                if (prev_pend && (bus.wb_adr_o !== prev_beat.adr || bus.wb_dat_o !== prev_beat.dat ||
                                  bus.wb_sel_o !== prev_beat.sel)) proto_err++;
                if (wcnt >= cur_delay) begin
                    bus.wb_ack_i = 1'b1;
                    wcnt = 0;
                    obs_q.push_back('{bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o});
                    cur_delay = rnd_ack ? int'($urandom_range(0, 5)) : ack_delay;
                    prev_pend = 1'b0;
                end else begin
                    bus.wb_ack_i = 1'b0;
                    wcnt++;
                    prev_pend = 1'b1;
                    prev_beat = '{bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o};
                end
            end else begin
                // stray acks while not in a bus cycle must be ignored
                bus.wb_ack_i = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b0;
                wcnt = 0;
                prev_pend = 1'b0;
                cur_delay = rnd_ack ? int'($urandom_range(0, 5)) : ack_delay;
            end
        end
    end

    // Reference model: a command is len+1 writes of the same word at
    // addr + i*STEP, modulo 2^27.
    task automatic model_cmd(input logic [26:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [7:0] l);
        logic [31:0] t;
        for (int i = 0; i <= int'(l); i++) begin
            t = {5'b0, a} + 32'(i * int'(STEP));
            exp_q.push_back('{t[26:0], d, s});
        end
    endtask

    task automatic send(input logic [26:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [7:0] l, input bit model);
        int n = 0;
        @(negedge clk);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_addr  = a;
        bus.i_cmd_data  = d;
        bus.i_cmd_sel   = s;
        bus.i_cmd_len   = l;
        while (bus.o_cmd_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL accept_wait: o_cmd_ready never rose (t=%0t)", $time);
        end
        if (model) model_cmd(a, d, s, l);
        @(negedge clk);
        // scramble the command inputs; the running command must not see this
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_addr  = 27'($urandom);
        bus.i_cmd_data  = $urandom;
        bus.i_cmd_sel   = 4'($urandom);
        bus.i_cmd_len   = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL idle_wait: o_busy stuck high (t=%0t)", $time);
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_beat_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            beat_t o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_adr"}, 32'(o.adr), 32'(e.adr));
            check({tag, "_dat"}, o.dat, e.dat);
            check({tag, "_sel"}, 32'(o.sel), 32'(e.sel));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            adr           dat           sel   len   dly   beats last          done err cyc
        vec[0] = '{27'h0001000, 32'hDEADBEEF, 4'hF, 8'd0, 2,    1, 27'h0001000, 1, 0, 3};
        vec[1] = '{27'h0010000, 32'h12345678, 4'h3, 8'd3, 0,    4, 27'h001000C, 1, 0, 4};
        vec[2] = '{27'h7FFFFFC, 32'hA5A5A5A5, 4'hC, 8'd1, 1,    2, 27'h0000000, 1, 0, 4};
        vec[3] = '{27'h0000100, 32'h0BADF00D, 4'hF, 8'd2, 1000, 0, 27'h0000000, 0, 1, 8};
        vec[4] = '{27'h0000200, 32'hCAFEF00D, 4'h1, 8'd0, 0,    1, 27'h0000200, 1, 0, 1};
        vec[5] = '{27'h0000400, 32'h11223344, 4'h6, 8'd1, 7,    2, 27'h0000404, 1, 0, 16};
        vec[6] = '{27'h0000800, 32'h55667788, 4'h9, 8'd0, 8,    0, 27'h0000000, 0, 1, 8};

        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_addr  = '0;
        bus.i_cmd_data  = '0;
        bus.i_cmd_sel   = '0;
        bus.i_cmd_len   = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_cyc",  32'(bus.wb_cyc_o), 0);
        check("rst_adr",  32'(bus.wb_adr_o), 0);
        check("rst_dat",  bus.wb_dat_o, 0);
        check("rst_sel",  32'(bus.wb_sel_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err",  32'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.o_cmd_ready), 1);

        // directed table: single beat, burst, wrap, timeouts, ack on the timeout cycle
        for (int i = 0; i < NV; i++) begin
            obs_q.delete();
            exp_q.delete();
            rnd_ack   = 1'b0;
            ack_delay = vec[i].delay;
            @(negedge clk);
            done_cnt = 0;
            cyc_cnt  = 0;
            send(vec[i].adr, vec[i].dat, vec[i].sel, vec[i].len, vec[i].err == 0);
            wait_idle();
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_beats", i), 32'(obs_q.size()), 32'(vec[i].beats));
            if (vec[i].beats > 0 && obs_q.size() > 0)
                check($sformatf("v%0d_last_adr", i), 32'(obs_q[$].adr), 32'(vec[i].last));
            check($sformatf("v%0d_done", i), 32'(done_cnt), 32'(vec[i].ndone));
            check($sformatf("v%0d_err", i),  32'(err), 32'(vec[i].err));
            check($sformatf("v%0d_cyc", i),  32'(cyc_cnt), 32'(vec[i].ncyc));
            compare_model($sformatf("v%0d", i));
        end

        // backpressure: valid held through a burst, second command taken on the done cycle
        begin
            int bp_err = 0;
            int seen   = 0;
            ack_delay = 0;
            @(negedge clk);
            done_cnt = 0;
            bus.i_cmd_valid = 1'b1;
            bus.i_cmd_addr  = 27'h0020000;
            bus.i_cmd_data  = 32'hAAAA0001;
            bus.i_cmd_sel   = 4'hF;
            bus.i_cmd_len   = 8'd3;
            check("bp_ready_a", 32'(bus.o_cmd_ready), 1);
            model_cmd(27'h0020000, 32'hAAAA0001, 4'hF, 8'd3);
            @(negedge clk);
            bus.i_cmd_addr  = 27'h0030000;
            bus.i_cmd_data  = 32'hBBBB0002;
            bus.i_cmd_sel   = 4'h5;
            bus.i_cmd_len   = 8'd2;
            for (int n = 0; n < 100; n++) begin
                if (done === 1'b1) begin
                    seen = 1;
                    check("bp_ready_on_done", 32'(bus.o_cmd_ready), 1);
                    break;
                end
                if (bus.o_cmd_ready !== 1'b0) bp_err++;
                @(negedge clk);
            end
            check("bp_done_seen", 32'(seen), 1);
            check("bp_ready_low", 32'(bp_err), 0);
            model_cmd(27'h0030000, 32'hBBBB0002, 4'h5, 8'd2);
            @(negedge clk);
            bus.i_cmd_valid = 1'b0;
            check("bp_b_accepted", 32'(busy), 1);
            wait_idle();
            repeat (2) @(negedge clk);
            check("bp_done_cnt", 32'(done_cnt), 2);
            compare_model("bp");
        end

        // randomized commands with random ack latency and stray idle acks
        rnd_ack = 1'b1;
        @(negedge clk);
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            logic [26:0] a;
            a = ($urandom_range(0, 3) == 0) ? 27'h7FFFFC0 + 27'($urandom_range(0, 15) * 4)
                                             : 27'($urandom);
            send(a, $urandom, 4'($urandom), 8'($urandom_range(0, 15)), 1'b1);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        rnd_ack = 1'b0;
        check("rnd_done_cnt", 32'(done_cnt), 30);
        check("rnd_err", 32'(err), 0);
        compare_model("rnd");

        // reset in the middle of a burst after three acks
        begin
            int n = 0;
            ack_delay = 0;
            repeat (2) @(negedge clk);
            obs_q.delete();
            done_cnt = 0;
            send(27'h0040000, 32'hFEEDFACE, 4'hF, 8'd7, 1'b0);
            while (obs_q.size() < 3 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            rst_n = 1'b0;
            #1;
            check("mr_cyc",  32'(bus.wb_cyc_o), 0);
            check("mr_stb",  32'(bus.wb_stb_o), 0);
            check("mr_we",   32'(bus.wb_we_o), 0);
            check("mr_adr",  32'(bus.wb_adr_o), 0);
            check("mr_dat",  bus.wb_dat_o, 0);
            check("mr_busy", 32'(busy), 0);
            check("mr_err",  32'(err), 0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("mr_ready", 32'(bus.o_cmd_ready), 1);
            check("mr_beats", 32'(obs_q.size()), 3);
            if (obs_q.size() == 3) check("mr_last_adr", 32'(obs_q[2].adr), 32'h0040008);
            repeat (3) @(negedge clk);
            check("mr_no_done", 32'(done_cnt), 0);
            check("mr_no_err", 32'(err), 0);
            obs_q.delete();
        end

        check("protocol", 32'(proto_err), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_gpu_loader.md
WB_GPU_LOADER -- requirements
Module: wb_gpu_loader

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the number of cycles a beat waits for wb_ack_i before abort (range 1..255).
REQ-002 Parameter ADDR_STEP, default 4, SHALL set the address increment between beats of one command.
REQ-003 clk_100MHz  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_cmd_valid  input  1  SHALL flag a command offered.
REQ-006 o_cmd_ready  output  1  SHALL flag that the loader accepts a command this cycle.
REQ-007 i_cmd_addr  input  27  SHALL be the first-beat Wishbone address.
REQ-008 i_cmd_data  input  32  SHALL be the write data, repeated on every beat (fill).
REQ-009 i_cmd_sel  input  4  SHALL be the byte select for every beat.
REQ-010 i_cmd_len  input  8  SHALL be the beat count minus one (0 = 1 beat, 255 = 256 beats).
REQ-011 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  SHALL be the Wishbone classic master cycle, strobe and write-enable.
REQ-012 wb_adr_o  output  27, wb_dat_o  output  32, wb_sel_o  output  4  SHALL be the master address, data and select.
REQ-013 wb_ack_i  input  1  SHALL be the slave acknowledge.
REQ-014 o_busy  output  1  SHALL be high whenever state is not IDLE.
REQ-015 o_done  output  1  SHALL pulse one cycle when a command's last beat is acknowledged.
REQ-016 o_error  output  1  SHALL be a sticky timeout flag.

Function
REQ-017 States SHALL be IDLE, BUS, ABORT.
REQ-018 o_cmd_ready SHALL equal (state == IDLE); a command SHALL be accepted when i_cmd_valid & o_cmd_ready at a clock edge.
REQ-019 On accept: addr, data, sel, remaining = i_cmd_len latched; state -> BUS; o_error cleared; wb_cyc_o = wb_stb_o = wb_we_o = 1 from the next cycle.
REQ-020 In BUS, wb_adr_o/wb_dat_o/wb_sel_o SHALL be stable while wb_stb_o high and ack not seen.
REQ-021 On wb_ack_i in BUS with remaining != 0: address += ADDR_STEP, remaining -= 1, timeout counter cleared, cyc/stb stay high (back-to-back beats, one beat per cycle max).
REQ-022 On wb_ack_i in BUS with remaining == 0: state -> IDLE, cyc/stb/we low next cycle, o_done high for exactly that next cycle.
REQ-023 Address arithmetic SHALL be 27-bit modulo 2^27 (wrap from 0x7FFFFFC to 0x0000000 with ADDR_STEP 4).
REQ-024 Timeout counter (8-bit) SHALL increment each BUS cycle without ack; when it reaches TIMEOUT without ack, state -> ABORT.
REQ-025 ABORT SHALL last one cycle with cyc/stb low, set o_error, discard remaining beats, then -> IDLE; o_done SHALL NOT pulse.
REQ-026 wb_ack_i outside BUS SHALL be ignored.
REQ-027 Ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as ack (no abort).
REQ-028 wb_cyc_o and wb_stb_o SHALL always be equal; wb_we_o SHALL equal wb_cyc_o (write-only master).
REQ-029 Inputs i_cmd_* SHALL be sampled only at accept; later changes have no effect on the running command.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE, wb_cyc_o/stb/we = 0, wb_adr_o = 0, wb_dat_o = 0, wb_sel_o = 0, o_busy = 0, o_done = 0, o_error = 0, counters 0, o_cmd_ready = 1 after release.
REQ-031 Reset asserted mid-command SHALL drop cyc/stb asynchronously and abandon the command without o_done or o_error.

Verification
REQ-032 Single beat: addr 0x0001000, data 0xDEADBEEF, sel 0xF, len 0, ack 2 cycles after stb -> one write at 0x0001000, o_done one cycle after ack, cyc low same cycle.
REQ-033 Burst fill: addr 0x0010000, len 3, ack every cycle -> writes at 0x0010000/004/008/00C on 4 consecutive cycles, o_done once.
REQ-034 Wrap: addr 0x7FFFFFC, len 1 -> beats at 0x7FFFFFC then 0x0000000.
REQ-035 Timeout: TIMEOUT 8, never ack -> cyc high 8 cycles, ABORT, o_error = 1, no o_done; next accepted command clears o_error.
REQ-036 Reset mid-burst: len 7, reset_n low after 3 acks -> cyc/stb 0 immediately, all outputs at reset values, o_cmd_ready 1 after release.
REQ-037 Backpressure: i_cmd_valid held high during burst -> o_cmd_ready 0 until IDLE, second command accepted exactly on the o_done cycle's state (IDLE), never dropped.
